// File: rtl/adc_frame_packer.sv
// Buffers whole 128-bit ADC frames in a FIFO and replays each admitted frame
// as a 64-bit AXI-Stream packet: one sequence-numbered header, then payload.
module adc_frame_packer #(
    parameter int unsigned DEPTH_LOG2  = 9,
    parameter int unsigned FRAME_BEATS = 128
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         enable,
    input  logic [127:0] s_axis_adc_tdata,
    input  logic         s_axis_adc_tvalid,
    output logic [63:0]  m_axis_tdata,
    output logic [7:0]   m_axis_tkeep,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [31:0]  frame_seq,
    output logic [31:0]  drop_count
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned FW    = FRAME_BEATS / 2;
    localparam int unsigned WCW   = (FW > 1) ? $clog2(FW) : 1;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PCW   = $clog2(FRAME_BEATS + 1);

    localparam logic [WCW-1:0] WLAST     = WCW'(FW - 1);
    localparam logic [CW-1:0]  ADMIT_MAX = CW'(DEPTH - FW);
    localparam logic [PCW-1:0] PLAST     = PCW'(FRAME_BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

    logic [127:0]          mem [DEPTH];
    logic [127:0]          rd_word_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_addr;
    logic [CW-1:0]         occ_q, occ_d, cfr_q, cfr_d;
    logic [WCW-1:0]        wcnt_q;
    logic                  admit_q;
    logic [31:0]           drop_q, seq_q;

    state_t                state_q;
    logic [63:0]           tdata_q;
    logic                  tvalid_q, tlast_q, hi_next_q;
    logic [PCW-1:0]        pcnt_q;

    logic                  frame_start, admit_now, drop_now, wr_en, wr_last;
    logic                  accept, hdr_start, pop;
    logic [63:0]           header;

    always_comb begin
        frame_start = s_axis_adc_tvalid && (wcnt_q == '0);
        admit_now   = frame_start && enable && (occ_q <= ADMIT_MAX);
        drop_now    = frame_start && enable && (occ_q > ADMIT_MAX);
        wr_en       = s_axis_adc_tvalid && (frame_start ? admit_now : admit_q);
        wr_last     = wr_en && (wcnt_q == WLAST);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wcnt_q   <= '0;
            admit_q  <= 1'b0;
            wr_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            if (s_axis_adc_tvalid) begin
                wcnt_q <= (wcnt_q == WLAST) ? '0 : wcnt_q + 1'b1;
                if (frame_start)
                    admit_q <= admit_now;
            end
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (drop_now && (drop_q != '1))
                drop_q <= drop_q + 1'b1;
        end
    end

    always_comb begin
        accept    = tvalid_q && m_axis_tready;
        hdr_start = (cfr_q != '0) &&
                    ((state_q == S_IDLE) || ((state_q == S_PAY) && accept && tlast_q));
        pop       = (state_q == S_PAY) && accept && !tlast_q && hi_next_q;
        rd_addr   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        header    = {seq_q, 16'hADC0, 16'(FRAME_BEATS)};

        occ_d = occ_q;
        if (wr_en && !pop)
            occ_d = occ_q + 1'b1;
        else if (!wr_en && pop)
            occ_d = occ_q - 1'b1;

        cfr_d = cfr_q;
        if (wr_last && !hdr_start)
            cfr_d = cfr_q + 1'b1;
        else if (!wr_last && hdr_start)
            cfr_d = cfr_q - 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            occ_q <= '0;
            cfr_q <= '0;
        end else begin
            occ_q <= occ_d;
            cfr_q <= cfr_d;
        end
    end

    // Read address looks one word ahead on a pop so the next word is already
    // registered when its low half is needed on the following beat.
    always_ff @(posedge ACLK) begin
        if (wr_en)
            mem[wr_ptr_q] <= s_axis_adc_tdata;
        rd_word_q <= mem[rd_addr];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            hi_next_q <= 1'b0;
            pcnt_q    <= '0;
            rd_ptr_q  <= '0;
            seq_q     <= '0;
        end else begin
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (hdr_start) begin
                        state_q  <= S_HDR;
                        tvalid_q <= 1'b1;
                        tdata_q  <= header;
                        tlast_q  <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        seq_q     <= seq_q + 1'b1;
                        state_q   <= S_PAY;
                        tdata_q   <= rd_word_q[63:0];
                        tlast_q   <= 1'b0;
                        hi_next_q <= 1'b1;
                        pcnt_q    <= PCW'(1);
                    end
                end
                S_PAY: begin
                    if (accept) begin
                        if (tlast_q) begin
                            tlast_q <= 1'b0;
                            if (hdr_start) begin
                                state_q <= S_HDR;
                                tdata_q <= header;
                            end else begin
                                state_q  <= S_IDLE;
                                tvalid_q <= 1'b0;
                                tdata_q  <= '0;
                            end
                        end else begin
                            tdata_q   <= hi_next_q ? rd_word_q[127:64] : rd_word_q[63:0];
                            hi_next_q <= !hi_next_q;
                            pcnt_q    <= pcnt_q + 1'b1;
                            tlast_q   <= (pcnt_q == PLAST);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tkeep  = {8{tvalid_q}};
    assign frame_seq     = seq_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer: a frame-level model queues expected
// beats at admission time; a negedge monitor pops and compares accepted beats.
module tb_adc_frame_packer;
    localparam int unsigned DL2   = 4;
    localparam int unsigned FB    = 8;
    localparam int unsigned FW    = FB / 2;
    localparam int unsigned DEPTH = 2 ** DL2;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         enable = 1'b0;
    logic [127:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         m_tready = 1'b1;
    logic [63:0]  m_tdata;
    logic [7:0]   m_tkeep;
    logic         m_tvalid, m_tlast;
    logic [31:0]  frame_seq, drop_count;

    adc_frame_packer #(.DEPTH_LOG2(DL2), .FRAME_BEATS(FB)) dut (
        .ACLK              (ACLK),
        .ARESETN           (ARESETN),
        .enable            (enable),
        .s_axis_adc_tdata  (s_tdata),
        .s_axis_adc_tvalid (s_tvalid),
        .m_axis_tdata      (m_tdata),
        .m_axis_tkeep      (m_tkeep),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .m_axis_tlast      (m_tlast),
        .frame_seq         (frame_seq),
        .drop_count        (drop_count)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        hi;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned n_cmp = 0, n_bad = 0;
    int unsigned m_wcnt = 0, m_written = 0, m_emitted = 0, m_seq = 0, m_drop = 0;
    bit          m_admit = 0;
    int unsigned beats_acc = 0;
    int unsigned rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // tready patterns: 0 high, 1 toggle, 2 low, 3 random (75% high)
    initial forever begin
        @(posedge ACLK); #1;
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = !m_tready;
            2: m_tready = 1'b0;
            default: m_tready = ($urandom_range(3) != 0);
        endcase
    end

    logic        stall_q = 1'b0, held_l = 1'b0;
    logic [63:0] held_d = '0;
    bit          in_frame = 0;
    beat_t       b;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            stall_q  = 1'b0;
            in_frame = 0;
        end else begin
            if (stall_q) begin
                check("stall_valid", 64'(m_tvalid), 64'(1));
                check("stall_data", m_tdata, held_d);
                check("stall_last", 64'(m_tlast), 64'(held_l));
            end
            if (in_frame)
                check("no_bubble", 64'(m_tvalid), 64'(1));
            check("tkeep", 64'(m_tkeep), m_tvalid ? 64'hFF : 64'h0);
            if (m_tvalid && m_tready) begin
                beats_acc++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %h expected no beat at %0t", m_tdata, $time);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", m_tdata, b.data);
                    check("beat_last", 64'(m_tlast), 64'(b.last));
                    if (b.hi)
                        m_emitted++;
                    in_frame = !b.last;
                end
            end
            stall_q = m_tvalid && !m_tready;
            held_d  = m_tdata;
            held_l  = m_tlast;
        end
    end

    task automatic idle();
        s_tvalid = 1'b0;
        @(posedge ACLK); #1;
    endtask

    // Admission is decided from words written minus words fully emitted; the
    // DUT may already have fetched one more word, so a frame start is held off
    // while that one-word uncertainty straddles the admission threshold.
    task automatic put_word(input logic [127:0] d, input bit en);
        int unsigned tries = 0;
        if (m_wcnt == 0) begin
            while (en && (m_written - m_emitted == DEPTH - FW + 1) && tries < 2000) begin
                idle();
                tries++;
            end
            if (tries >= 2000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL admit_wait: got occupancy %0d expected it to drain", m_written - m_emitted);
            end
            m_admit = 0;
            if (en) begin
                if (m_written - m_emitted <= DEPTH - FW) begin
                    m_admit = 1;
                    exp_q.push_back('{data: {m_seq[31:0], 16'hADC0, 16'(FB)}, last: 1'b0, hi: 1'b0});
                    m_seq++;
                end else begin
                    m_drop++;
                end
            end
        end
        if (m_admit) begin
            m_written++;
            exp_q.push_back('{data: d[63:0], last: 1'b0, hi: 1'b0});
            exp_q.push_back('{data: d[127:64], last: (m_wcnt == FW - 1), hi: 1'b1});
        end
        s_tvalid = 1'b1;
        s_tdata  = d;
        enable   = en;
        @(posedge ACLK); #1;
        s_tvalid = 1'b0;
        m_wcnt   = (m_wcnt + 1) % FW;
    endtask

    function automatic logic [127:0] word_of(input int unsigned f, input int unsigned i);
        return {4{32'(f * 16 + i + 1)}};
    endfunction

    task automatic send_frame(input int unsigned f, input bit en0, input bit en_rest, input bit rnd);
        logic [127:0] d;
        for (int unsigned i = 0; i < FW; i++) begin
            if (rnd) begin
                repeat ($urandom_range(2)) idle();
                d = {$urandom, $urandom, $urandom, $urandom};
                put_word(d, (i == 0) ? en0 : bit'($urandom_range(1)));
            end else begin
                put_word(word_of(f, i), (i == 0) ? en0 : en_rest);
            end
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_wcnt = 0; m_written = 0; m_emitted = 0; m_seq = 0; m_drop = 0; m_admit = 0;
    endtask

    task automatic reset_dut();
        ARESETN  = 1'b0;
        s_tvalid = 1'b0;
        clear_model();
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int unsigned t = 0;
        while ((exp_q.size() != 0 || m_tvalid) && t < 3000) begin
            @(posedge ACLK); #1;
            t++;
        end
        check({name, "_drain"}, 64'(exp_q.size()), 64'(0));
        repeat (5) idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base, t;

        // Reset values
        ARESETN = 1'b0;
        #200;
        check("rst_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_tlast", 64'(m_tlast), 64'(0));
        check("rst_tkeep", 64'(m_tkeep), 64'(0));
        check("rst_tdata", m_tdata, 64'(0));
        check("rst_frame_seq", 64'(frame_seq), 64'(0));
        check("rst_drop_count", 64'(drop_count), 64'(0));
        @(posedge ACLK); #1 ARESETN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge ACLK); #1;
            check("idle_tvalid", 64'(m_tvalid), 64'(0));
        end

        // Single frame, with header latency after the last write
        rdy_mode = 0;
        send_frame(0, 1, 1, 0);
        @(posedge ACLK); #1;
        check("latency_tvalid", 64'(m_tvalid), 64'(1));
        check("first_header", m_tdata, 64'h00000000_ADC0_0008);
        wait_drain("single");
        check("single_seq", 64'(frame_seq), 64'(1));

        // Backpressure: toggling tready over two identical frames
        reset_dut();
        rdy_mode = 1;
        send_frame(0, 1, 1, 0);
        send_frame(0, 1, 1, 0);
        wait_drain("backpressure");
        check("bp_seq", 64'(frame_seq), 64'(2));

        // Overflow: six frames into a stalled output, four fit
        reset_dut();
        rdy_mode = 2;
        m_tready = 1'b0;
        for (int unsigned f = 1; f <= 6; f++)
            send_frame(f, 1, 1, 0);
        repeat (3) idle();
        check("ovf_drop_count", 64'(drop_count), 64'(2));
        check("ovf_model_drops", 64'(m_drop), 64'(2));
        rdy_mode = 0;
        wait_drain("overflow");
        check("ovf_seq", 64'(frame_seq), 64'(4));

        // Enable dropped on word 1: that frame completes, later frames ignored
        send_frame(7, 1, 0, 0);
        send_frame(8, 0, 0, 0);
        send_frame(9, 0, 0, 0);
        wait_drain("enable");
        check("en_drop_count", 64'(drop_count), 64'(2));
        check("en_seq", 64'(frame_seq), 64'(5));

        // Reset while payload beat 3 is presented
        base = beats_acc;
        send_frame(10, 1, 1, 0);
        t = 0;
        while (beats_acc < base + 3 && t < 500) begin
            @(posedge ACLK); #1;
            t++;
        end
        check("mid_reset_reach", 64'(beats_acc - base), 64'(3));
        ARESETN = 1'b0;
        #1;
        check("mid_reset_tvalid", 64'(m_tvalid), 64'(0));
        check("mid_reset_tdata", m_tdata, 64'(0));
        check("mid_reset_seq", 64'(frame_seq), 64'(0));
        clear_model();
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        send_frame(11, 1, 1, 0);
        wait_drain("post_reset");
        check("post_reset_seq", 64'(frame_seq), 64'(1));

        // Randomized traffic with random tready, gaps and enables
        reset_dut();
        rdy_mode = 3;
        for (int unsigned f = 0; f < 40; f++)
            send_frame(f, ($urandom_range(9) != 0), 1, 1);
        rdy_mode = 0;
        wait_drain("random");
        check("rand_drop_count", 64'(drop_count), 64'(m_drop));
        check("rand_seq", 64'(frame_seq), 64'(m_seq));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
